// File: rtl/dbus_bridge.sv
// Data-side bus bridge: routes CPU word loads/stores to a synchronous data RAM
// or to memory-mapped LED, switch and cycle-counter registers.
module dbus_bridge #(
  parameter int RAM_AW = 10,
  parameter int LED_W  = 16,
  parameter int SW_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;
  typedef enum logic [2:0] {T_RAM, T_LED, T_SW, T_CNT, T_NONE} tgt_t;

  // Word-address decode; byte lane bits never reach the decoder.
  function automatic tgt_t f_decode(input logic [29:0] w);
    tgt_t t;
    t = T_NONE;
    if (w[29:RAM_AW] == '0)         t = T_RAM;
    else if (w == 30'h3FFF_FFC0)    t = T_LED;
    else if (w == 30'h3FFF_FFC1)    t = T_SW;
    else if (w == 30'h3FFF_FFC2)    t = T_CNT;
    return t;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  tgt_t              r_tgt;
  tgt_t              w_tgt_in;
  logic              r_we;
  logic [31:0]       r_rdata;
  logic              r_ready;
  logic              r_err;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic [LED_W-1:0]  r_led;
  logic [31:0]       r_cnt;
  logic [SW_W-1:0]   r_sw_s1;
  logic [SW_W-1:0]   r_sw_s2;
  logic [1:0]        w_unused_addr_lsb;

  assign w_unused_addr_lsb = cpu_addr[1:0];
  assign w_tgt_in          = f_decode(cpu_addr[31:2]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (cpu_req) w_state_nxt = S_ACCESS;
      S_ACCESS:  w_state_nxt = (r_tgt == T_RAM && !r_we) ? S_CAPTURE : S_RESP;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tgt       <= T_NONE;
      r_we        <= 1'b0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_led       <= '0;
      r_cnt       <= '0;
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= (w_state_nxt == S_RESP);
      r_err    <= (w_state_nxt == S_RESP) && (r_tgt == T_NONE);
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
      r_cnt    <= r_cnt + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we        <= cpu_we;
            r_tgt       <= w_tgt_in;
            r_ram_addr  <= cpu_addr[RAM_AW+1:2];
            r_ram_wdata <= cpu_wdata;
            r_ram_en    <= (w_tgt_in == T_RAM);
            r_ram_we    <= (w_tgt_in == T_RAM) && cpu_we;
          end
        end
        S_ACCESS: begin
          // I/O side effects and I/O read data both resolve on this edge.
          if (r_we) begin
            if (r_tgt == T_LED) r_led <= r_ram_wdata[LED_W-1:0];
            if (r_tgt == T_CNT) r_cnt <= r_ram_wdata;
          end else begin
            case (r_tgt)
              T_LED:   r_rdata <= 32'(r_led);
              T_SW:    r_rdata <= 32'(r_sw_s2);
              T_CNT:   r_rdata <= r_cnt;
              T_NONE:  r_rdata <= '0;
              default: r_rdata <= r_rdata;
            endcase
          end
        end
        S_CAPTURE: r_rdata <= ram_rdata;
        default: ;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_ready = r_ready;
  assign bus_err   = r_err;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign led_out   = r_led;

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge: directed and random bus transactions checked against a
// memory-map reference model with an arithmetic cycle-counter model.
module tb_dbus_bridge;
  localparam int RAM_AW = 10;
  localparam int LED_W  = 16;
  localparam int SW_W   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              bus_err;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [SW_W-1:0]   sw_in = '0;
  logic [LED_W-1:0]  led_out;

  dbus_bridge #(.RAM_AW(RAM_AW), .LED_W(LED_W), .SW_W(SW_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .bus_err(bus_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM device with one-cycle read latency.
  logic [31:0] ram [0:(1<<RAM_AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]      ref_mem [int];
  int               wq [$];
  logic [LED_W-1:0] ref_led = '0;
  logic [SW_W-1:0]  ref_sw = '0;
  logic [31:0]      ref_rdata = '0;
  logic [31:0]      cnt_val = '0;
  int               cnt_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_sw(input logic [SW_W-1:0] v);
    sw_in  = v;
    ref_sw = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One CPU transaction, started #1 after a clock edge with the bridge idle.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit hold);
    int c, lat, exp_lat, widx;
    bit is_ram, is_led, is_sw, is_cnt, unm;
    logic [31:0] word;
    widx   = int'(addr >> 2);
    word   = addr & 32'hFFFF_FFFC;
    is_ram = (addr >> 2) < 32'(1 << RAM_AW);
    is_led = (word == 32'hFFFF_FF00);
    is_sw  = (word == 32'hFFFF_FF04);
    is_cnt = (word == 32'hFFFF_FF08);
    unm    = !(is_ram || is_led || is_sw || is_cnt);
    exp_lat = (is_ram && !we) ? 3 : 2;

    c = cyc;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
    chk("ram_en_access", 32'(ram_en), 32'(is_ram));
    chk("ram_we_access", 32'(ram_we), 32'(is_ram && we));
    if (is_ram) chk("ram_addr", 32'(ram_addr), addr >> 2);
    if (is_ram && we) chk("ram_wdata", ram_wdata, wdata);

    if (we) begin
      if (is_ram) begin
        ref_mem[widx] = wdata;
        wq.push_back(widx);
      end
      if (is_led) ref_led = wdata[LED_W-1:0];
      if (is_cnt) begin cnt_val = wdata; cnt_cyc = c + 2; end
    end else begin
      if (is_ram)      ref_rdata = ref_mem[widx];
      else if (is_led) ref_rdata = 32'(ref_led);
      else if (is_sw)  ref_rdata = 32'(ref_sw);
      else if (is_cnt) ref_rdata = cnt_val + 32'(c + 1 - cnt_cyc);
      else             ref_rdata = '0;
    end

    lat = -1;
    for (int k = 0; k < 8; k++) begin
      if (cpu_ready) begin lat = cyc - c; break; end
      @(posedge clk); #1;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (lat >= 0) begin
      chk("bus_err", 32'(bus_err), 32'(unm));
      chk("rdata", cpu_rdata, ref_rdata);
      chk("led_out", 32'(led_out), 32'(ref_led));
      chk("ram_en_resp", 32'(ram_en), 32'd0);
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
    chk("err_pulse", 32'(bus_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, idx;
    logic [31:0] v;

    // Reset and idle state
    repeat (3) @(posedge clk);
    #1;
    cnt_cyc = cyc; cnt_val = '0;
    rst = 1'b0;
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_ready", 32'(cpu_ready), 32'd0);
    txn(1'b0, 32'hFFFF_FF08, 32'h0, 1'b1);

    // RAM store/load, including ignored byte-lane bits
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    txn(1'b0, 32'h0000_0010, 32'h0, 1'b1);
    txn(1'b0, 32'h0000_0013, 32'h0, 1'b1);
    txn(1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b0);
    txn(1'b0, 32'h0000_0FFC, 32'h0, 1'b0);

    // LED and switches
    txn(1'b1, 32'hFFFF_FF00, 32'h0000_A5A5, 1'b1);
    txn(1'b0, 32'hFFFF_FF00, 32'h0, 1'b1);
    set_sw(16'h1234);
    txn(1'b0, 32'hFFFF_FF04, 32'h0, 1'b1);
    txn(1'b1, 32'hFFFF_FF04, 32'hFFFF_FFFF, 1'b1);

    // Counter wrap
    txn(1'b1, 32'hFFFF_FF08, 32'hFFFF_FFFE, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    txn(1'b0, 32'hFFFF_FF08, 32'h0, 1'b1);

    // Unmapped accesses
    txn(1'b0, 32'h8000_0000, 32'h0, 1'b1);
    txn(1'b1, 32'h0000_1000, 32'h5555_AAAA, 1'b0);
    txn(1'b0, 32'hFFFF_FF0C, 32'h0, 1'b1);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 6));
      case (kind)
        0: txn(1'b1, ($urandom & 32'h0000_0FFF), $urandom, 1'($urandom_range(0, 1)));
        1: begin
             idx = wq[$urandom_range(0, wq.size() - 1)];
             txn(1'b0, (32'(idx) << 2) | 32'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)));
           end
        2: txn(1'b1, 32'hFFFF_FF00, $urandom, 1'b1);
        3: txn(1'b0, 32'hFFFF_FF00, 32'h0, 1'($urandom_range(0, 1)));
        4: begin
             set_sw(SW_W'($urandom));
             txn(1'b0, 32'hFFFF_FF04, 32'h0, 1'b1);
           end
        5: txn(1'($urandom_range(0, 1)), 32'hFFFF_FF08, $urandom, 1'b1);
        default: txn(1'($urandom_range(0, 1)), 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF),
                     $urandom, 1'b1);
      endcase
    end

    // Reset asserted while a RAM store is in ACCESS
    v = $urandom;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = v;
    @(posedge clk); #1;
    chk("mid_rst_ram_en", 32'(ram_en), 32'd1);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    cnt_cyc = cyc; cnt_val = '0;
    rst = 1'b0;
    ref_mem[16] = v; wq.push_back(16);
    ref_led = '0; ref_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      chk("mid_rst_no_ready", 32'(cpu_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("mid_rst_led", 32'(led_out), 32'd0);
    chk("mid_rst_rdata", cpu_rdata, 32'd0);
    txn(1'b0, 32'h0000_0040, 32'h0, 1'b1);
    txn(1'b0, 32'hFFFF_FF08, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
